instr_fetch_unit: RTL and testbench

Instruction fetch front end that drives the instruction ROM and hands fetched words to decode. Keeps the program counter, issues one word-address read per cycle into a synchronous ROM with one cycle of read latency, and queues the returned words in a 2-entry buffer. The buffer drains through a valid/ready handshake to decode. A one-cycle redirect port reloads the PC and squashes every older fetch.

---
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM read port, redirect request and decode handshake.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 4
);
    localparam int unsigned DATA_W = 32;

    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_en, imem_addr,
        input  imem_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, one-cycle-latency ROM read issue and a 2-entry
// in-order buffer draining to decode, with a squashing redirect port.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned       DATA_W = 32;
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    logic              run_q, run_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              hd_vld_q, hd_vld_d;
    logic [DATA_W-1:0] hd_data_q, hd_data_d;
    logic [ADDR_W-1:0] hd_pc_q, hd_pc_d;
    logic              tl_vld_q, tl_vld_d;
    logic [DATA_W-1:0] tl_data_q, tl_data_d;
    logic [ADDR_W-1:0] tl_pc_q, tl_pc_d;

    logic [1:0] cnt;
    logic       pop;
    logic       push;
    logic       issue;

    assign cnt  = 2'(hd_vld_q) + 2'(tl_vld_q);
    assign pop  = hd_vld_q & bus.instr_ready;
    assign push = infl_q;
    // Issue only if the returning word is guaranteed a slot, crediting this cycle's pop.
    assign issue = run_q & ~bus.redirect_valid
                 & ((3'(cnt) + 3'(infl_q)) < (3'd2 + 3'(pop)));

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = hd_vld_q;
    assign bus.instr_data  = hd_data_q;
    assign bus.instr_pc    = hd_pc_q;

    always_comb begin
        run_d     = 1'b1;
        pc_d      = pc_q;
        infl_d    = issue;
        infl_pc_d = infl_pc_q;
        hd_vld_d  = hd_vld_q;
        hd_data_d = hd_data_q;
        hd_pc_d   = hd_pc_q;
        tl_vld_d  = tl_vld_q;
        tl_data_d = tl_data_q;
        tl_pc_d   = tl_pc_q;

        if (issue) begin
            pc_d      = pc_q + ADDR_W'(1);
            infl_pc_d = pc_q;
        end

        // Redirect empties the buffer and drops the response landing this edge.
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            hd_vld_d = 1'b0;
            tl_vld_d = 1'b0;
        end else begin
            if (pop) begin
                hd_vld_d  = tl_vld_q;
                hd_data_d = tl_data_q;
                hd_pc_d   = tl_pc_q;
                tl_vld_d  = 1'b0;
            end
            if (push) begin
                if (!hd_vld_d) begin
                    hd_vld_d  = 1'b1;
                    hd_data_d = bus.imem_data;
                    hd_pc_d   = infl_pc_q;
                end else begin
                    tl_vld_d  = 1'b1;
                    tl_data_d = bus.imem_data;
                    tl_pc_d   = infl_pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            pc_q      <= PC_RST;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            hd_vld_q  <= 1'b0;
            hd_data_q <= '0;
            hd_pc_q   <= '0;
            tl_vld_q  <= 1'b0;
            tl_data_q <= '0;
            tl_pc_q   <= '0;
        end else begin
            run_q     <= run_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            hd_vld_q  <= hd_vld_d;
            hd_data_q <= hd_data_d;
            hd_pc_q   <= hd_pc_d;
            tl_vld_q  <= tl_vld_d;
            tl_data_q <= tl_data_d;
            tl_pc_q   <= tl_pc_d;
        end
    end

    // A returning word must never find the buffer full with nothing leaving.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt == 2'd2) && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing steps plus a random stream checked
// against an in-order model (consecutive PCs from the last reset/redirect target).
module tb_instr_fetch_unit;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [DEPTH];

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int delivered = 0;
    int base_cnt;
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input int rpc);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = ADDR_W'(rpc);
        #1;
    endtask

    // Model step: a completed handshake must carry the next PC in program order.
    task automatic adv();
        if (bus.instr_valid && bus.instr_ready) begin
            chk("stream_pc", 32'(bus.instr_pc), 32'(exp_pc));
            chk("stream_data", bus.instr_data, rom[exp_pc]);
            exp_pc = exp_pc + ADDR_W'(1);
            delivered++;
        end
        if (bus.redirect_valid) exp_pc = bus.redirect_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic startup(input logic rdy3);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("pre_e0_imem_en", 32'(bus.imem_en), 32'h0);
        @(posedge clk);
        #1;
        exp_pc = '0;
        drive(1'b1, 1'b0, 0);
        chk("c1_imem_en", 32'(bus.imem_en), 32'h1);
        chk("c1_imem_addr", 32'(bus.imem_addr), 32'h0);
        chk("c1_valid", 32'(bus.instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("c2_valid", 32'(bus.instr_valid), 32'h0);
        chk("c2_imem_addr", 32'(bus.imem_addr), 32'h1);
        adv();
        drive(rdy3, 1'b0, 0);
        chk("c3_valid", 32'(bus.instr_valid), 32'h1);
        chk("c3_pc", 32'(bus.instr_pc), 32'h0);
        chk("c3_data", bus.instr_data, rom[0]);
        chk("c3_imem_en", 32'(bus.imem_en), 32'(rdy3));
        adv();
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        exp_pc             = '0;
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
        rom[0] = 32'h01234567;
        rom[1] = 32'h89ABCDEF;
        rom[2] = 32'h123A1234;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_en", 32'(bus.imem_en), 32'h0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_data", bus.instr_data, 32'h0);
        chk("rst_pc", 32'(bus.instr_pc), 32'h0);

        // Reset release and streaming, then redirect while head pc 2 is accepted
        startup(1'b1);
        drive(1'b1, 1'b0, 0);
        chk("c4_pc", 32'(bus.instr_pc), 32'h1);
        adv();
        drive(1'b1, 1'b1, 5);
        chk("c5_valid", 32'(bus.instr_valid), 32'h1);
        chk("c5_pc", 32'(bus.instr_pc), 32'h2);
        adv();
        chk("consumed_with_redirect", 32'(delivered), 32'd3);
        drive(1'b1, 1'b0, 0);
        chk("r1_valid", 32'(bus.instr_valid), 32'h0);
        chk("r1_imem_en", 32'(bus.imem_en), 32'h1);
        chk("r1_imem_addr", 32'(bus.imem_addr), 32'h5);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("r2_valid", 32'(bus.instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("r3_valid", 32'(bus.instr_valid), 32'h1);
        chk("r3_pc", 32'(bus.instr_pc), 32'h5);
        adv();
        repeat (2) begin drive(1'b1, 1'b0, 0); adv(); end

        // Back-to-back redirects: last one wins
        drive(1'b1, 1'b1, 5);
        adv();
        drive(1'b1, 1'b1, 7);
        chk("bb_valid", 32'(bus.instr_valid), 32'h0);
        chk("bb_imem_en", 32'(bus.imem_en), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("bb1_imem_addr", 32'(bus.imem_addr), 32'h7);
        chk("bb1_valid", 32'(bus.instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("bb2_valid", 32'(bus.instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("bb3_valid", 32'(bus.instr_valid), 32'h1);
        chk("bb3_pc", 32'(bus.instr_pc), 32'h7);
        adv();

        // Wrap through 2^ADDR_W-1
        drive(1'b1, 1'b1, 14);
        adv();
        repeat (2) begin
            drive(1'b1, 1'b0, 0);
            chk("wrap_gap_valid", 32'(bus.instr_valid), 32'h0);
            adv();
        end
        for (int i = 0; i < 4; i++) begin
            w = ADDR_W'(14 + i);
            drive(1'b1, 1'b0, 0);
            chk("wrap_valid", 32'(bus.instr_valid), 32'h1);
            chk("wrap_pc", 32'(bus.instr_pc), 32'(w));
            chk("wrap_data", bus.instr_data, rom[w]);
            adv();
        end

        // Asynchronous reset between edges
        drive(1'b1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.instr_valid), 32'h0);
        chk("async_imem_en", 32'(bus.imem_en), 32'h0);
        chk("async_data", bus.instr_data, 32'h0);
        chk("async_pc", 32'(bus.instr_pc), 32'h0);
        @(posedge clk);
        #1;

        // Restart with decode stalled from the first valid
        startup(1'b0);
        repeat (5) begin
            drive(1'b0, 1'b0, 0);
            chk("bp_imem_en", 32'(bus.imem_en), 32'h0);
            chk("bp_valid", 32'(bus.instr_valid), 32'h1);
            chk("bp_pc", 32'(bus.instr_pc), 32'h0);
            adv();
        end
        base_cnt = delivered;
        drive(1'b1, 1'b0, 0);
        chk("bp_restart_en", 32'(bus.imem_en), 32'h1);
        chk("bp_restart_addr", 32'(bus.imem_addr), 32'h2);
        adv();
        repeat (3) begin drive(1'b1, 1'b0, 0); adv(); end
        chk("bp_delivered", 32'(delivered - base_cnt), 32'd4);

        // Redirect to 9 with pc 1 buffered and pc 2 returning
        drive(1'b1, 1'b1, 1);
        adv();
        repeat (2) begin drive(1'b0, 1'b0, 0); adv(); end
        drive(1'b0, 1'b1, 9);
        chk("sq_head_pc", 32'(bus.instr_pc), 32'h1);
        chk("sq_imem_en", 32'(bus.imem_en), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("sq1_valid", 32'(bus.instr_valid), 32'h0);
        chk("sq1_imem_addr", 32'(bus.imem_addr), 32'h9);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("sq2_valid", 32'(bus.instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 0);
        chk("sq3_valid", 32'(bus.instr_valid), 32'h1);
        chk("sq3_pc", 32'(bus.instr_pc), 32'h9);
        adv();

        // Random backpressure and redirects
        base_cnt = delivered;
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, DEPTH - 1)));
            adv();
        end
        repeat (4) begin drive(1'b1, 1'b0, 0); adv(); end
        chk("rand_progress", 32'(delivered > base_cnt + 100), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
